// File: rtl/ro_freq_counter_if.sv
// Front-end bus for ro_freq_counter: measurement request, busy/done status
// and the latched result. The register/AXI side is the master.
interface ro_freq_counter_if #(
  parameter int CNT_W  = 32,
  parameter int GATE_W = 24
);
  logic              start;
  logic [GATE_W-1:0] gate_cycles;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output start,
    output gate_cycles,
    input  busy,
    input  done,
    input  count,
    input  overflow
  );

  modport slave (
    input  start,
    input  gate_cycles,
    output busy,
    output done,
    output count,
    output overflow
  );
endinterface

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter. Enables the RO, lets it settle, counts
// synchronized rising edges over a gate window of G clk cycles and reports
// the saturating count with a single-cycle done pulse.
module ro_freq_counter #(
  parameter int CNT_W      = 32,
  parameter int GATE_W     = 24,
  parameter int SETTLE_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ro_clk,
  output logic              o_ro_en,
  ro_freq_counter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // SETTLE_CYC >= 4, so the settle counter is always at least 2 bits wide.
  localparam int                SET_W       = $clog2(SETTLE_CYC);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [SET_W-1:0]  SET_ONE     = {{(SET_W-1){1'b0}}, 1'b1};
  localparam logic [GATE_W-1:0] GATE_ONE    = {{(GATE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [SET_W-1:0]  r_settle_cnt;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_acc;
  logic              r_acc_ovf;
  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              r_ro_en;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic              w_edge;
  logic [CNT_W-1:0]  w_acc_next;
  logic              w_ovf_next;

  // 2-FF synchronizer plus delay flop for rising-edge detection of the RO.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_ro_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  // Saturating accumulator update; overflow flags an edge lost at all-ones.
  always_comb begin
    w_acc_next = r_acc;
    w_ovf_next = r_acc_ovf;
    if (w_edge) begin
      if (&r_acc) begin
        w_ovf_next = 1'b1;
      end else begin
        w_acc_next = r_acc + CNT_ONE;
      end
    end else begin
      w_acc_next = r_acc;
      w_ovf_next = r_acc_ovf;
    end
  end

  // Measurement FSM; all outputs are registered and updated on transitions.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= {SET_W{1'b0}};
      r_gate_cnt   <= {GATE_W{1'b0}};
      r_acc        <= {CNT_W{1'b0}};
      r_acc_ovf    <= 1'b0;
      r_ro_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_count      <= {CNT_W{1'b0}};
      r_overflow   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_acc        <= {CNT_W{1'b0}};
            r_acc_ovf    <= 1'b0;
            r_settle_cnt <= {SET_W{1'b0}};
            r_gate_cnt   <= bus.gate_cycles;
            if (bus.gate_cycles != {GATE_W{1'b0}}) begin
              r_state <= ST_SETTLE;
              r_ro_en <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              // Zero-length gate: report an empty result without enabling the RO.
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_count    <= {CNT_W{1'b0}};
              r_overflow <= 1'b0;
            end
          end
        end
        ST_SETTLE: begin
          // Edges are ignored here so the synchronizer fills from the resting-high level.
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= ST_COUNT;
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_ONE;
          end
        end
        ST_COUNT: begin
          r_acc     <= w_acc_next;
          r_acc_ovf <= w_ovf_next;
          if (r_gate_cnt == GATE_ONE) begin
            // Last gate cycle: its edge is included in the published result.
            r_state    <= ST_DONE;
            r_ro_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_count    <= w_acc_next;
            r_overflow <= w_ovf_next;
          end else begin
            r_gate_cnt <= r_gate_cnt - GATE_ONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ro_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ro_en      = r_ro_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;

endmodule

// File: doc/ro_freq_counter.md
# ro_freq_counter

Measures the frequency of one gated ring oscillator (RO) in the system clock domain. The block enables the RO, waits a settle interval, then counts RO rising edges over a programmable gate window and reports the count with a one-cycle done pulse. It sits between each RO sensor instance, which it drives and reads, and the register/AXI front end that issues `start` and collects `count`. This gives one aging/reliability frequency sample per request.

## Interface
- `CNT_W`, 32: width of the edge count result.
- `GATE_W`, 24: width of the gate-window length, in `clk` cycles.
- `SETTLE_CYC`, 16: number of `clk` cycles between `ro_en` rising and the start of counting. Legal values are ≥ 4.

- `clk`, input, 1: system clock. Every flop in the block is on this clock.
- `rst_n`, input, 1: synchronous reset, active low.
- `start`, input, 1: single-cycle measurement request. It is sampled only in IDLE.
- `gate_cycles`, input, `GATE_W`: gate window length. It is latched when `start` is accepted.
- `ro_clk`, input, 1: RO output. It is asynchronous to `clk` and rests high while the RO is disabled.
- `ro_en`, output, 1: RO enable.
- `busy`, output, 1: high while a measurement is in progress.
- `done`, output, 1: one-cycle pulse that marks `count` and `overflow` as updated.
- `count`, output, `CNT_W`: last measured edge count. It holds its value until the next `done`.
- `overflow`, output, 1: set when the last measurement saturated.

## Operation
- `ro_clk` passes through a 2-FF synchronizer `s1`→`s2` plus a delay flop `s3`. A rising edge is detected when `s2 & ~s3`.
- `ro_clk` frequency must be below f(`clk`)/4. The block does not check this; a faster RO undercounts.
- The FSM states are IDLE, SETTLE, COUNT and DONE.
  - **IDLE:** `ro_en`=0 and `busy`=0.
    - On `start`=1 with `gate_cycles`≠0: latch G, clear the accumulator and the overflow flag, clear the settle counter, then go to SETTLE.
    - On `start`=1 with `gate_cycles`=0: go to DONE with accumulator 0 and overflow 0. `ro_en` is never asserted.
  - **SETTLE:** `ro_en`=1 and `busy`=1. Edges are ignored, so the synchronizer fills and the resting-high level never counts as an edge. After `SETTLE_CYC` cycles, go to COUNT.
  - **COUNT:** `ro_en`=1 and `busy`=1.
    - Each cycle with a detected edge increments the accumulator.
    - At all-ones the accumulator saturates and the overflow flag sets.
    - After exactly G cycles, go to DONE. An edge detected in the last COUNT cycle is counted.
  - **DONE:** `ro_en`=0 and `busy`=0. This state lasts one cycle:
    - `done`=1;
    - `count` and `overflow` are loaded from the accumulator and flag;
    - the FSM returns to IDLE.
- `start` in SETTLE, COUNT or DONE is ignored, with no queuing.
- The gate counter is `GATE_W` bits wide and counts down from G, so G = 2^`GATE_W`−1 is legal.
- Reset mid-operation returns the FSM to IDLE at the next `clk` edge. No `done` pulse is produced.

## Timing
- Reset values: FSM state IDLE; `ro_en`, `busy`, `done`, `overflow` and `count` all 0; synchronizer flops 0.
- Take `start` accepted at edge 0.
  - `ro_en` and `busy` rise after edge 0.
  - SETTLE occupies cycles 1..`SETTLE_CYC`.
  - COUNT occupies cycles `SETTLE_CYC`+1..`SETTLE_CYC`+G.
  - `done`=1 and the new `count` is visible in cycle `SETTLE_CYC`+G+1; `ro_en` and `busy` are low in that same cycle.
  - The earliest next `start` that is accepted is in cycle `SETTLE_CYC`+G+2.
- Total latency from `start` to `done` is `SETTLE_CYC`+G+1 cycles. With `gate_cycles`=0, `done` arrives in cycle 1.
- `count` and `overflow` change only in the `done` cycle or on reset.
- Expected result: `count` ≈ G·f_ro/f_clk, with ±1 quantization.

## Test plan
- Basic measurement: `ro_clk` model with a period of 10 `clk`, G=1000, `SETTLE_CYC`=16 → `done` in cycle 1017, `count` in 99..101, `overflow`=0, `ro_en` high for cycles 1..1016.
- Zero gate: `start` with `gate_cycles`=0 → `done` in cycle 1, `count`=0, `ro_en` stays 0 throughout.
- Saturation: `CNT_W`=8, `ro_clk` period 4 `clk`, G=2000 → `count`=255, `overflow`=1. A following run with G=100 → `count` ≈ 25, `overflow`=0.
- Busy protection: `start` pulses in SETTLE, mid-COUNT and in the DONE cycle → exactly one `done`, and timing is unchanged from the basic measurement case.
- Reset mid-COUNT: `rst_n`=0 for 1 cycle at cycle 500 of the basic measurement case → next cycle `ro_en`=0, `busy`=0, `count`=0, no `done`. A new `start` afterwards completes normally.
- Stuck RO: `ro_clk` held at 1 (disabled RO), G=500 → `count`=0, `overflow`=0, `done` in cycle 517.
